// File: rtl/l2_cache_pkg.sv
// Shared L2 cache types: tree-PLRU word, way select, sweep FSM states.
package l2_cache_pkg;

  typedef logic [2:0] plru_t;
  typedef logic [1:0] way_t;

  localparam plru_t PLRU_RESET = 3'b000;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/l2_plru_next.sv
// Combinational 4-way tree-PLRU helper.
// It returns the word after an access to way_in, and the victim for plru_in.
module l2_plru_next
  import l2_cache_pkg::*;
(
  input  plru_t plru_in,
  input  way_t  way_in,
  output plru_t plru_next,
  output way_t  victim
);

  // Touch the two tree bits on the path to way_in; pick the victim by walking away from recent use
  always_comb begin
    plru_next = plru_in;
    victim    = 2'd3;
    case (way_in)
      2'd0: begin plru_next[0] = 1'b0; plru_next[1] = 1'b0; end
      2'd1: begin plru_next[0] = 1'b0; plru_next[1] = 1'b1; end
      2'd2: begin plru_next[0] = 1'b1; plru_next[2] = 1'b0; end
      default: begin plru_next[0] = 1'b1; plru_next[2] = 1'b1; end
    endcase
    if (plru_in[0]) begin
      victim = plru_in[1] ? 2'd0 : 2'd1;
    end else begin
      victim = plru_in[2] ? 2'd2 : 2'd3;
    end
  end

endmodule

// File: rtl/l2_lru_array.sv
// Per-set tree-PLRU store for the 4-way L2.
// It applies hit/fill updates, returns a registered victim on lookup, and
// provides a flush sweep that zeroes every set.
// Optional macro L2_LRU_BYPASS_EN: a same-index update forwards into a
// same-cycle lookup, so the lookup sees the post-update word.
module l2_lru_array
  import l2_cache_pkg::*;
#(
  parameter int NUM_SETS = 32,
  parameter int IDX_W    = $clog2(NUM_SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rd_valid,
  input  logic [IDX_W-1:0] rd_index,
  output logic             rd_ready,
  output logic             resp_valid,
  output logic [1:0]       resp_way,
  output logic [2:0]       resp_lru,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_index,
  input  logic [1:0]       upd_way,
  input  logic             flush_req,
  output logic             busy,
  output logic             flush_done
);

  sweep_state_t     state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  plru_t            plru_q [NUM_SETS];
  plru_t            plru_d [NUM_SETS];
  logic             resp_valid_q, resp_valid_d;
  way_t             resp_way_q, resp_way_d;
  plru_t            resp_lru_q, resp_lru_d;
  logic             flush_done_q, flush_done_d;

  logic  upd_en, rd_en;
  plru_t upd_word, rd_word;
  plru_t lkp_next_unused;
  way_t  upd_victim_unused;
  way_t  rd_victim;

  assign busy       = (state_q == SWEEP);
  assign rd_ready   = ~busy;
  assign upd_en     = upd_valid & rd_ready;
  assign rd_en      = rd_valid & rd_ready;
  assign resp_valid = resp_valid_q;
  assign resp_way   = resp_way_q;
  assign resp_lru   = resp_lru_q;
  assign flush_done = flush_done_q;

  l2_plru_next u_upd (
    .plru_in   (plru_q[upd_index]),
    .way_in    (upd_way),
    .plru_next (upd_word),
    .victim    (upd_victim_unused)
  );

  // Word seen by the lookup, optionally forwarded from a same-set update
  always_comb begin
    rd_word = plru_q[rd_index];
`ifdef L2_LRU_BYPASS_EN
    if (upd_en && (upd_index == rd_index)) begin
      rd_word = upd_word;
    end
`endif
  end

  l2_plru_next u_lkp (
    .plru_in   (rd_word),
    .way_in    (upd_way),
    .plru_next (lkp_next_unused),
    .victim    (rd_victim)
  );

  // Next value of every set: the sweep clears one set per cycle, otherwise accepted updates land
  always_comb begin
    for (int i = 0; i < NUM_SETS; i++) begin
      plru_d[i] = plru_q[i];
      if (upd_en && (upd_index == IDX_W'(i))) begin
        plru_d[i] = upd_word;
      end
      if (busy && (cnt_q == IDX_W'(i))) begin
        plru_d[i] = PLRU_RESET;
      end
    end
  end

  // Sweep sequencing plus registered lookup response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      default: begin
        if (cnt_q == IDX_W'(NUM_SETS - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_W'(1);
        end
      end
    endcase
    // Registered so that it lines up with the final sweep cycle
    flush_done_d = (state_d == SWEEP) && (cnt_d == IDX_W'(NUM_SETS - 1));

    resp_valid_d = rd_en;
    resp_lru_d   = rd_en ? rd_word : resp_lru_q;
    resp_way_d   = rd_en ? rd_victim : resp_way_q;
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_way_q   <= '0;
      resp_lru_q   <= PLRU_RESET;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_way_q   <= resp_way_d;
      resp_lru_q   <= resp_lru_d;
      flush_done_q <= flush_done_d;
    end
  end

  // One flop word per set so reset clears the whole array at once
  for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        plru_q[gi] <= PLRU_RESET;
      end else begin
        plru_q[gi] <= plru_d[gi];
      end
    end
  end

endmodule

// File: tb/tb_l2_lru_array.sv
// Scoreboard bench for l2_lru_array: a reference PLRU/sweep model predicts
// every cycle's busy/flush_done/response; lookup results travel in a queue.
module tb_l2_lru_array;

  localparam int NUM_SETS = 32;
  localparam int IDX_W    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             rd_valid;
  logic [IDX_W-1:0] rd_index;
  logic             rd_ready;
  logic             resp_valid;
  logic [1:0]       resp_way;
  logic [2:0]       resp_lru;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_index;
  logic [1:0]       upd_way;
  logic             flush_req;
  logic             busy;
  logic             flush_done;

  always #5 clk = ~clk;

  l2_lru_array #(.NUM_SETS(NUM_SETS), .IDX_W(IDX_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_valid   (rd_valid),
    .rd_index   (rd_index),
    .rd_ready   (rd_ready),
    .resp_valid (resp_valid),
    .resp_way   (resp_way),
    .resp_lru   (resp_lru),
    .upd_valid  (upd_valid),
    .upd_index  (upd_index),
    .upd_way    (upd_way),
    .flush_req  (flush_req),
    .busy       (busy),
    .flush_done (flush_done)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [2:0] m_plru [NUM_SETS];
  bit         m_busy;
  int         m_cnt;
  bit         m_resp_pend;
  logic [2:0] m_last_lru;
  logic [1:0] m_last_way;
  logic [4:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_update(input logic [2:0] b, input logic [1:0] w);
    logic [2:0] r;
    r = b;
    case (w)
      2'd0: begin r[0] = 1'b0; r[1] = 1'b0; end
      2'd1: begin r[0] = 1'b0; r[1] = 1'b1; end
      2'd2: begin r[0] = 1'b1; r[2] = 1'b0; end
      default: begin r[0] = 1'b1; r[2] = 1'b1; end
    endcase
    return r;
  endfunction

  function automatic logic [1:0] ref_victim(input logic [2:0] b);
    if (b[0]) return b[1] ? 2'd0 : 2'd1;
    return b[2] ? 2'd2 : 2'd3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_SETS; i++) m_plru[i] = 3'b000;
    m_busy      = 1'b0;
    m_cnt       = 0;
    m_resp_pend = 1'b0;
    m_last_lru  = 3'b000;
    m_last_way  = 2'd0;
    exp_q.delete();
  endtask

  task automatic set_in(input bit rv, input logic [IDX_W-1:0] ri, input bit uv,
                        input logic [IDX_W-1:0] ui, input logic [1:0] uw, input bit fr);
    rd_valid  = rv;
    rd_index  = ri;
    upd_valid = uv;
    upd_index = ui;
    upd_way   = uw;
    flush_req = fr;
  endtask

  // Advance the model across the coming rising edge using the driven inputs
  task automatic model_step();
    logic [2:0] w;
    bit accept;
    accept      = !m_busy;
    m_resp_pend = accept && rd_valid;
    if (m_resp_pend) begin
      w = m_plru[rd_index];
`ifdef L2_LRU_BYPASS_EN
      if (upd_valid && (upd_index == rd_index)) w = ref_update(w, upd_way);
`endif
      exp_q.push_back({w, ref_victim(w)});
    end
    if (accept && upd_valid) m_plru[upd_index] = ref_update(m_plru[upd_index], upd_way);
    if (m_busy) begin
      m_plru[m_cnt] = 3'b000;
      if (m_cnt == NUM_SETS - 1) begin
        m_busy = 1'b0;
        m_cnt  = 0;
      end else begin
        m_cnt++;
      end
    end else if (flush_req) begin
      m_busy = 1'b1;
      m_cnt  = 0;
    end
  endtask

  task automatic check_outputs();
    logic [4:0] e;
    check_eq("busy", busy, m_busy);
    check_eq("rd_ready", rd_ready, !m_busy);
    check_eq("flush_done", flush_done, m_busy && (m_cnt == NUM_SETS - 1));
    check_eq("resp_valid", resp_valid, m_resp_pend);
    if (m_resp_pend) begin
      e = exp_q.pop_front();
      m_last_lru = e[4:2];
      m_last_way = e[1:0];
      $display("lookup resp: lru=%b way=%0d (expected lru=%b way=%0d)", resp_lru, resp_way, m_last_lru, m_last_way);
    end
    check_eq("resp_lru", resp_lru, m_last_lru);
    check_eq("resp_way", resp_way, m_last_way);
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle_tick();
    set_in(0, '0, 0, '0, 2'd0, 0);
    tick();
  endtask

  task automatic populate_all();
    for (int i = 0; i < NUM_SETS; i++) begin
      set_in(0, '0, 1, IDX_W'(i), 2'($urandom_range(1, 3)), 0);
      tick();
    end
  endtask

  task automatic lookup_all();
    for (int i = 0; i < NUM_SETS; i++) begin
      set_in(1, IDX_W'(i), 0, '0, 2'd0, 0);
      tick();
      check_eq("set_zero", resp_lru, 3'b000);
    end
    idle_tick();
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, '0, 0, '0, 2'd0, 0);
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs();

    // lookup after reset
    set_in(1, 5'd5, 0, '0, 2'd0, 0);
    tick();
    check_eq("rst_set5_way", resp_way, 2'd3);
    idle_tick();

    // consecutive updates compose, then look up
    set_in(0, '0, 1, 5'd2, 2'd3, 0);
    tick();
    set_in(0, '0, 1, 5'd2, 2'd1, 0);
    tick();
    set_in(1, 5'd2, 0, '0, 2'd0, 0);
    tick();
    check_eq("set2_lru", resp_lru, 3'b110);
    check_eq("set2_way", resp_way, 2'd2);

    // same-cycle update and lookup on set 7
    set_in(1, 5'd7, 1, 5'd7, 2'd0, 0);
    tick();
    check_eq("same7_w0_lru", resp_lru, 3'b000);
    set_in(1, 5'd7, 1, 5'd7, 2'd2, 0);
    tick();
`ifdef L2_LRU_BYPASS_EN
    check_eq("same7_w2_lru", resp_lru, 3'b001);
    check_eq("same7_w2_way", resp_way, 2'd1);
`else
    check_eq("same7_w2_lru", resp_lru, 3'b000);
    check_eq("same7_w2_way", resp_way, 2'd3);
`endif
    set_in(1, 5'd7, 0, '0, 2'd0, 0);
    tick();
    check_eq("set7_after_lru", resp_lru, 3'b001);

    // full sweep with lookups pressed during it
    populate_all();
    set_in(0, '0, 1, 5'd3, 2'd2, 1);  // update together with flush_req
    tick();
    for (int i = 0; i < NUM_SETS; i++) begin
      set_in(1, 5'($urandom_range(0, NUM_SETS - 1)), 1, 5'd4, 2'd3, 0);
      tick();
    end
    check_eq("sweep_over", busy, 1'b0);
    lookup_all();

    // reset in the middle of a sweep
    populate_all();
    set_in(0, '0, 0, '0, 2'd0, 1);
    tick();
    for (int i = 0; i < 10; i++) idle_tick();
    #1 rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_done", flush_done, 1'b0);
    check_eq("midrst_rv", resp_valid, 1'b0);
    check_eq("midrst_lru", resp_lru, 3'b000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();
    lookup_all();
    set_in(0, '0, 0, '0, 2'd0, 1);
    tick();
    for (int i = 0; i < NUM_SETS + 2; i++) idle_tick();

    // random accept-qualified traffic against the model
    for (int n = 0; n < 10000; n++) begin
      logic [IDX_W-1:0] ri;
      ri = 5'($urandom_range(0, NUM_SETS - 1));
      set_in(1'($urandom_range(0, 1)), ri, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? ri : 5'($urandom_range(0, NUM_SETS - 1)),
             2'($urandom_range(0, 3)), ($urandom_range(0, 299) == 0));
      tick();
    end
    idle_tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
